// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// The FSM state and the access owner are visible to the top, the selector and the bench.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Grant selection for the memory arbiter.
// Data has fixed priority until it has won STARVE_LIMIT grants in a row while fetch waited.
module mem_arbiter_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   grant,
  output logic   grant_dm,
  output owner_t owner
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            starved;

  assign starved  = if_req && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant    = (state == IDLE) && (if_req || dm_req);
  assign grant_dm = dm_req && !starved;

  // starve_cnt only advances on a data grant that left fetch waiting;
  // a fetch grant, or a grant with no fetch pending, restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      owner      <= OWN_IF;
    end else if (grant) begin
      owner <= grant_dm ? OWN_DM : OWN_IF;
      if (grant_dm && if_req) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port multi-cycle memory between instruction fetch and data access.
// One access at a time: IDLE -> ISSUE -> WAIT -> RESP, with a one-cycle done pulse in RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int LATENCY      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t           state;
  owner_t           owner;
  logic             grant;
  logic             grant_dm;
  logic             op_wr;
  logic [CNT_W-1:0] cnt;

  assign dbg_state = state;

  mem_arbiter_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant   (grant),
    .grant_dm(grant_dm),
    .owner   (owner)
  );

  // Handshake: if_req/dm_req are levels held with their address/data until the
  // matching done pulse; done is high for exactly the RESP cycle and requests
  // are only sampled in IDLE, so a request still high during RESP is not a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= ISSUE;
            mem_enable <= 1'b1;
            if (grant_dm) begin
              op_wr       <= dm_wr;
              mem_wr      <= dm_wr;
              mem_addr    <= dm_addr;
              mem_data_in <= dm_wdata;
            end else begin
              // Fetch is read-only.
              op_wr    <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (op_wr) begin
            // Stores occupy the memory for LATENCY cycles; valid is not used.
            if (cnt == '0) begin
              state   <= RESP;
              dm_done <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end else if (mem_data_valid) begin
            state <= RESP;
            if (owner == OWN_DM) begin
              dm_rdata <= mem_data_out;
              dm_done  <= 1'b1;
            end else begin
              if_rdata <= mem_data_out;
              if_done  <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
